// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default bubble value for pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;
  localparam logic [31:0] BUBBLE_DEFAULT = 32'h0;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid register; in_ready comes from registered state only, so out_ready does not reach it combinationally
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  // Initialisers give the reset state at power-up in simulation
  state_e state_q = EMPTY;
  state_e state_d;
  logic [WIDTH-1:0] main_q = BUBBLE;
  logic [WIDTH-1:0] skid_q = BUBBLE;
  logic [WIDTH-1:0] main_d, skid_d;
  logic in_fire, out_fire;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = state_q == FULL ? 2'd2 : state_q == BUSY ? 2'd1 : 2'd0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = in_fire ? BUSY : EMPTY;
        main_d  = in_fire ? in_data : main_q;
      end
      BUSY: begin
        state_d = in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : BUSY;
        main_d  = in_fire && out_fire ? in_data : main_q;
        skid_d  = in_fire && !out_fire ? in_data : skid_q;
      end
      default: begin
        state_d = out_fire ? BUSY : FULL;
        main_d  = out_fire ? skid_q : main_q;
      end
    endcase
    // Flush drops stored entries and any same-cycle input; empty state masks stale data
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus randomized scoreboard run for pipe_skid_reg
module tb_pipe_skid_reg;
  logic clk = 0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0] occupancy;
  int n_pass = 0, n_total = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  typedef struct {
    logic r, f, v;
    logic [31:0] d;
    logic o;
    logic ev, er;
    logic [31:0] ed;
    logic [1:0] eo;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Drive one cycle: check current outputs against the scoreboard, advance the model, clock
  task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] d, input logic o);
    int sz;
    logic ifire, ofire;
    rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
    sz = sb.size();
    chk("out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, sz < 2});
    chk("occupancy", {30'b0, occupancy}, sz);
    chk("out_data", out_data, sz != 0 ? sb[0] : 32'h0);
    ifire = v && sz < 2;
    ofire = o && sz != 0;
    if (r) sb.delete();
    else begin
      if (ofire) void'(sb.pop_front());
      if (f) sb.delete();
      else if (ifire) sb.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    tbl[0]  = '{1, 0, 0, 32'h00, 0, 0, 1, 32'h00, 0};
    tbl[1]  = '{0, 0, 1, 32'h11, 1, 1, 1, 32'h11, 1};
    tbl[2]  = '{0, 0, 1, 32'h22, 1, 1, 1, 32'h22, 1};
    tbl[3]  = '{0, 0, 1, 32'h33, 1, 1, 1, 32'h33, 1};
    tbl[4]  = '{0, 0, 0, 32'h00, 1, 0, 1, 32'h00, 0};
    tbl[5]  = '{0, 0, 1, 32'h0A, 0, 1, 1, 32'h0A, 1};
    tbl[6]  = '{0, 0, 1, 32'h0B, 0, 1, 0, 32'h0A, 2};
    tbl[7]  = '{0, 0, 1, 32'h0C, 0, 1, 0, 32'h0A, 2};
    tbl[8]  = '{0, 0, 1, 32'h0C, 0, 1, 0, 32'h0A, 2};
    tbl[9]  = '{0, 0, 1, 32'h0C, 0, 1, 0, 32'h0A, 2};
    tbl[10] = '{0, 0, 1, 32'h0C, 0, 1, 0, 32'h0A, 2};
    tbl[11] = '{0, 0, 1, 32'h0C, 0, 1, 0, 32'h0A, 2};
    tbl[12] = '{0, 0, 1, 32'h0C, 1, 1, 1, 32'h0B, 1};
    tbl[13] = '{0, 0, 1, 32'h0C, 1, 1, 1, 32'h0C, 1};
    tbl[14] = '{0, 0, 0, 32'h00, 1, 0, 1, 32'h00, 0};
    tbl[15] = '{0, 0, 1, 32'h0A, 0, 1, 1, 32'h0A, 1};
    tbl[16] = '{0, 0, 1, 32'h0B, 0, 1, 0, 32'h0A, 2};
    tbl[17] = '{0, 1, 1, 32'h0D, 0, 0, 1, 32'h00, 0};
    tbl[18] = '{0, 0, 0, 32'h00, 1, 0, 1, 32'h00, 0};
    tbl[19] = '{0, 0, 1, 32'h55, 0, 1, 1, 32'h55, 1};
    tbl[20] = '{1, 0, 1, 32'h66, 0, 0, 1, 32'h00, 0};
    tbl[21] = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h00, 0};
    tbl[22] = '{0, 0, 1, 32'h77, 0, 1, 1, 32'h77, 1};
    tbl[23] = '{0, 1, 1, 32'h88, 1, 0, 1, 32'h00, 0};
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].o);
      chk($sformatf("vec%0d.valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d.ready", i), {31'b0, in_ready}, {31'b0, tbl[i].er});
      chk($sformatf("vec%0d.data", i), out_data, tbl[i].ed);
      chk($sformatf("vec%0d.occ", i), {30'b0, occupancy}, {30'b0, tbl[i].eo});
    end
    // Reset wins over flush in the same cycle, starting from FULL
    cyc(0, 0, 1, 32'h91, 0);
    cyc(0, 0, 1, 32'h92, 0);
    cyc(1, 1, 1, 32'h93, 1);
    chk("rst_over_flush.occ", {30'b0, occupancy}, 32'd0);
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
          $urandom, $urandom_range(0, 2) != 0);
    cyc(0, 0, 0, 32'h0, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload bit width (>=1).
REQ-002 SHALL have parameter BUBBLE, default 0 (WIDTH bits), value driven on out_data while empty.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  in  1  upstream data valid.
REQ-007 SHALL have port in_ready  out  1  block can accept in_data this cycle.
REQ-008 SHALL have port in_data  in  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  out  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  in  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_data  out  WIDTH  head payload.
REQ-012 SHALL have port occupancy  out  2  stored entries, 0..2.

Function
REQ-013 SHALL define input fire = in_valid & in_ready and output fire = out_valid & out_ready.
REQ-014 SHALL hold two entries, main (head) and skid, tracked by states EMPTY, BUSY (main only) and FULL (main+skid).
REQ-015 SHALL drive in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (state != EMPTY), out_data = main when valid, else BUBBLE.
REQ-017 SHALL transition EMPTY -> BUSY on input fire, loading main <= in_data.
REQ-018 SHALL keep BUSY on simultaneous input and output fire, loading main <= in_data.
REQ-019 SHALL transition BUSY -> FULL on input fire without output fire, loading skid <= in_data.
REQ-020 SHALL transition BUSY -> EMPTY on output fire without input fire.
REQ-021 SHALL transition FULL -> BUSY on output fire, moving main <= skid; no input is accepted in FULL.
REQ-022 SHALL hold state, main and skid unchanged when neither fire occurs, so out_data is stable while out_valid & !out_ready.
REQ-023 SHALL provide latency of 1 cycle from input fire in EMPTY to out_valid, with a sustained throughput of 1 item/cycle.
REQ-024 SHALL preserve strict FIFO order; no entry shall be lost or duplicated except by flush.
REQ-025 SHALL, on flush, move to EMPTY next cycle, discarding main, skid and any same-cycle input fire; out_valid=0 the following cycle.
REQ-026 SHALL give flush priority over all handshake transitions; an output fire in the flush cycle still counts as delivered.
REQ-027 SHALL drive occupancy 0/1/2 for EMPTY/BUSY/FULL.

Reset
REQ-028 SHALL, on rst, set state EMPTY, main and skid to BUBBLE, out_valid=0, in_ready=1, out_data=BUBBLE and occupancy=0, with rst priority over flush.
REQ-029 SHALL discard all stored entries when rst asserts mid-operation, with no partial update.
REQ-030 SHALL power up (initial) in the reset state for simulation.

Structure
REQ-031 SHALL place the state enum (EMPTY/BUSY/FULL) and the default BUBBLE constant in shared package pipe_pkg.
REQ-032 SHALL use no sub-module; main and skid shall be plain enabled registers inside the block.

Verification
REQ-033 SHALL cover stream: WIDTH=32, out_ready=1, in 0x11,0x22,0x33 on consecutive cycles -> outputs 0x11,0x22,0x33 one cycle later each, occupancy stays 1.
REQ-034 SHALL cover backpressure: out_ready=0, push 0xA,0xB -> occupancy 2, in_ready=0, 0xC held off; release out_ready -> 0xA,0xB,0xC in order.
REQ-035 SHALL cover stall hold: FULL with out_ready=0 for 5 cycles -> out_data stays 0xA, no state change.
REQ-036 SHALL cover flush: FULL plus flush with in_valid=1, data 0xD -> next cycle occupancy 0, out_valid=0, out_data=BUBBLE; 0xD never appears.
REQ-037 SHALL cover reset: rst mid-stream in BUSY -> next cycle occupancy 0, in_ready=1, out_data=0.
REQ-038 SHALL cover random: 10k cycles random valid/ready/flush against a scoreboard model -> no order or loss errors.
